// File: rtl/spi_receiver.sv
// spi_receiver
// ------------
// Oversampling SPI slave receiver. The three SPI pins are asynchronous to
// `clock` and are synchronized before any decision is made. Each complete
// frame of `bitcount` bits is presented on `data` with a one-cycle `valid`
// strobe. Frames that are cut short by select deassertion, or that carry
// more leading clock edges than `bitcount`, are dropped and reported with a
// one-cycle `error` strobe. `data` only ever changes on `valid`.
//
// Parameters
//   bitcount      bits per frame (>= 2)
//   ss_polarity   active level of `ss` (0 = active-low)
//   sclk_polarity idle level of `sclk`; data sampled on idle -> non-idle edge
//   msb_first     1: first bit lands in data[bitcount-1]; 0: in data[0]
//
// Ports
//   clock   in   system clock, rising edge
//   reset   in   synchronous, active-high
//   sclk    in   SPI clock (asynchronous)
//   ss      in   SPI slave select (asynchronous)
//   sdi     in   SPI serial data / MOSI (asynchronous)
//   data    out  last valid frame
//   valid   out  one-cycle strobe, `data` has just been updated
//   error   out  one-cycle strobe, a frame was aborted or overrun
//   busy    out  high while a frame is in progress

module spi_receiver #(
    parameter int unsigned bitcount      = 8,
    parameter bit          ss_polarity   = 1'b0,
    parameter bit          sclk_polarity = 1'b0,
    parameter bit          msb_first     = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                sclk,
    input  logic                ss,
    input  logic                sdi,
    output logic [bitcount-1:0] data,
    output logic                valid,
    output logic                error,
    output logic                busy
);

    localparam int unsigned          CntW    = $clog2(bitcount + 1);
    localparam logic [CntW-1:0]      CntFull = CntW'(bitcount);
    localparam logic [CntW-1:0]      CntOne  = CntW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StReceive,
        StDiscard
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizers
    // Index 0 = s1, 1 = s2, 2 = s3. sdi needs no edge detection, so it
    // only carries the two synchronizing stages.
    // ------------------------------------------------------------------
    logic [2:0] sclk_sync_q, sclk_sync_d;
    logic [2:0] ss_sync_q,   ss_sync_d;
    logic [1:0] sdi_sync_q,  sdi_sync_d;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], sclk};
        ss_sync_d   = {ss_sync_q[1:0], ss};
        sdi_sync_d  = {sdi_sync_q[0], sdi};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_sync_q <= {3{sclk_polarity}};
            ss_sync_q   <= {3{~ss_polarity}};
            sdi_sync_q  <= 2'b00;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            sdi_sync_q  <= sdi_sync_d;
        end
    end

    logic lead_edge;
    logic sel_s2;
    logic sel_s3;
    logic sel_rise;
    logic sel_fall;
    logic sdi_bit;

    always_comb begin
        lead_edge = (sclk_sync_q[2] == sclk_polarity) && (sclk_sync_q[1] != sclk_polarity);
        sel_s2    = (ss_sync_q[1] == ss_polarity);
        sel_s3    = (ss_sync_q[2] == ss_polarity);
        sel_rise  = sel_s2 && !sel_s3;
        sel_fall  = !sel_s2 && sel_s3;
        sdi_bit   = sdi_sync_q[1];
    end

    // ------------------------------------------------------------------
    // Post-reset settle counter
    // The synchronizer chain restarts from the inactive level, so a select
    // that was already active through reset would otherwise look like a
    // fresh assertion. settle_q == 2 marks the first cycle in which s2
    // holds a real pin sample; a select seen active there is treated as a
    // frame already in progress and is discarded.
    // ------------------------------------------------------------------
    logic [1:0] settle_q, settle_d;
    logic       first_look;

    always_comb begin
        settle_d   = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
        first_look = (settle_q == 2'd2);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            settle_q <= 2'd0;
        end else begin
            settle_q <= settle_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [bitcount-1:0]   shift_q, shift_d;
    logic [bitcount-1:0]   data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  error_q, error_d;

    logic [bitcount-1:0]   shift_src;
    logic [bitcount-1:0]   shift_in;
    logic [CntW-1:0]       cnt_upd;
    logic                  overrun;

    // An edge arriving together with the select assertion is bit 0 of a
    // freshly cleared frame, so the shift source is zero while idle.
    always_comb begin
        shift_src = (state_q == StIdle) ? '0 : shift_q;
        if (msb_first) begin
            shift_in = {shift_src[bitcount-2:0], sdi_bit};
        end else begin
            shift_in = {sdi_bit, shift_src[bitcount-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        cnt_upd = cnt_q;
        overrun = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (first_look && sel_s2) begin
                    state_d = StDiscard;
                end else if (sel_rise) begin
                    state_d = StReceive;
                    cnt_d   = '0;
                    shift_d = '0;
                    if (lead_edge) begin
                        shift_d = shift_in;
                        cnt_d   = CntOne;
                    end
                end
            end

            StReceive: begin
                // The edge is accounted for first; a deassertion in the
                // same cycle is then judged on the updated count.
                if (lead_edge) begin
                    if (cnt_q == CntFull) begin
                        overrun = 1'b1;
                        error_d = 1'b1;
                        state_d = StDiscard;
                    end else begin
                        shift_d = shift_in;
                        cnt_upd = cnt_q + CntOne;
                    end
                end
                cnt_d = cnt_upd;

                if (sel_fall) begin
                    state_d = StIdle;
                    if (!overrun) begin
                        if (cnt_upd == CntFull) begin
                            data_d  = shift_d;
                            valid_d = 1'b1;
                        end else if (cnt_upd != '0) begin
                            error_d = 1'b1;
                        end
                    end
                end
            end

            StDiscard: begin
                if (sel_fall) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        data  = data_q;
        valid = valid_q;
        error = error_q;
        busy  = (state_q != StIdle);
    end

endmodule

// File: doc/spi_receiver.md
# spi_receiver

Oversampling SPI receiver that captures serial frames driven by the SPI stimulus generator or any external SPI master, and presents each complete frame as a parallel word with a one-cycle valid strobe. All SPI inputs are asynchronous to `clock` and are synchronized before use. Frames cut short by slave-select deassertion, and frames carrying more clock edges than `bitcount`, are discarded and reported on `error`. The block sits at the chip's SPI slave pins and feeds register-file or FIFO logic.

## Interface
- `bitcount`, 8: bits per frame (≥ 2)
- `ss_polarity`, 0: active level of `ss` (0 = active-low)
- `sclk_polarity`, 0: idle level of `sclk`; data is sampled on the leading edge (idle → non-idle)
- `msb_first`, 1: 1 = first received bit lands in `data[bitcount-1]`; 0 = in `data[0]`
- `clock`  in  1  system clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high
- `sclk`  in  1  SPI clock, asynchronous
- `ss`  in  1  SPI slave select, asynchronous
- `sdi`  in  1  SPI serial data (MOSI), asynchronous
- `data`  out  bitcount  last valid frame
- `valid`  out  1  one-cycle strobe: `data` has just been updated
- `error`  out  1  one-cycle strobe: a frame was aborted or overrun
- `busy`  out  1  high while a frame is in progress (synchronized `ss` active)

## Operation
- Input path: each of `sclk`, `ss`, `sdi` passes through two synchronizer flops (s1, s2), plus a third flop (s3) for edge detection. All decisions use s2/s3 only.
- Leading edge: s3 == `sclk_polarity` and s2 != `sclk_polarity`. Select asserts when s3 is inactive and s2 active; deasserts on the reverse.
- Internal state: shift register (bitcount), bit counter (width clog2(bitcount+1)), and a state machine with states IDLE, RECEIVE, DISCARD.
- IDLE: on select assertion, clear the counter and the shift register and go to RECEIVE.
- RECEIVE, on a leading edge with counter < bitcount: shift in s2 of `sdi` per `msb_first` and increment the counter.
- RECEIVE, on a leading edge with counter == bitcount: overrun. Pulse `error` and go to DISCARD.
- RECEIVE, on select deassertion:
  - counter == bitcount: copy the shift register to `data`, pulse `valid`.
  - counter in 1..bitcount-1: pulse `error` (aborted frame).
  - counter == 0: no strobe.
  - In all three cases, go to IDLE.
- DISCARD: ignore all edges. Return to IDLE on select deassertion, with no further strobe.
- A leading edge and select deassertion in the same cycle: the edge is counted first, then the deassertion is evaluated with the updated count.
- A select assertion and a leading edge in the same cycle: the edge is counted as bit 0.
- `valid` and `error` are never high in the same cycle.
- At most one strobe is issued per frame.
- `data` holds its value between `valid` strobes. It is never modified by aborted or overrun frames.
- `busy` = state != IDLE.

## Timing
- Reset values: `data`=0, `valid`=0, `error`=0, `busy`=0, state=IDLE, counter=0, all synchronizer flops at the inactive/idle levels.
- Reset asserted mid-frame has priority over all other activity. It returns everything to the reset values.
- After reset release, if synchronized select is already active, enter DISCARD and wait for deassertion. A partial frame is never accepted and no error is flagged.
- Latency: a pin change first sampled at rising edge k is acted on at edge k+2. `valid`/`error` are therefore high in the cycle following edge k+2 after the sampled `ss` deassertion (overrun: after the sampled offending `sclk` edge).
- Input constraints:
  - Each `sclk` level and each `ss` level must be stable for ≥ 2 `clock` cycles.
  - `sdi` must be stable from 1 cycle before to 1 cycle after each leading `sclk` edge.
  - Violations give undefined data but never a lock-up: state always returns to IDLE on select deassertion.
- Throughput: back-to-back frames separated by ≥ 2 cycles of select inactive are each received.

## Test plan
- Reset and idle:
  - Stimulus: reset high 2 cycles with all inputs idle.
  - Required: all outputs 0, and no strobes for 20 cycles.
- Normal frame:
  - Stimulus: bitcount=4, msb_first=1, send 4'b1011 with leading edges 4 cycles apart, then deassert `ss`.
  - Required: `data`=4'hB with a single `valid` pulse 3 cycles after deassertion, and `busy` falls in the same cycle.
- Aborted frame:
  - Stimulus: `ss` asserted, 2 leading edges, then deassert.
  - Required: one `error` pulse, `data` stays 4'hB, no `valid`.
- Overrun:
  - Stimulus: 5 leading edges within one `ss` window.
  - Required: `error` pulse after the 5th edge, no `valid` at deassertion, `busy` stays high until deassertion.
- Mid-frame reset:
  - Stimulus: reset pulsed after 2 of 4 bits while `ss` remains active, then 2 more edges and deassert.
  - Required: no strobes. A following clean frame 4'h6 gives `valid` with `data`=4'h6.
- All four ss_polarity × sclk_polarity instances:
  - Stimulus: the frame 4'h5 in each mode, with msb_first=0 for one instance.
  - Required: 4'h5 in every instance, bit order correct per `msb_first`.
